// File: rtl/aes_pkg.sv
// Shared AES constants and block-wide vector types used by the round datapath
// and key-handling stages.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES128_NR   = 10;
    localparam int AES192_NR   = 12;
    localparam int AES256_NR   = 14;

    typedef logic [AES_BLOCK_W-1:0] state_t;
    typedef logic [AES_BLOCK_W-1:0] key_t;

endpackage

// File: rtl/round_key_bank.sv
// Round-key storage: one register and one valid bit per slot, a write/clear
// port with out-of-range flagging, and a combinational read port.
module round_key_bank
    import aes_pkg::*;
#(
    parameter int DATA_W   = AES_BLOCK_W,
    parameter int NUM_KEYS = AES128_NR + 1,
    parameter int IDX_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_we,
    input  logic [IDX_W-1:0]  key_idx,
    input  logic [DATA_W-1:0] key_data,
    input  logic              key_clear,
    output logic              key_err,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_key,
    output logic              rd_hit
);

    localparam logic [IDX_W:0] SLOT_LIMIT = (IDX_W + 1)'(NUM_KEYS);

    logic [DATA_W-1:0]   key_mem [NUM_KEYS];
    logic [NUM_KEYS-1:0] slot_valid;
    logic                wr_in_range;

    assign wr_in_range = ({1'b0, key_idx} < SLOT_LIMIT);

    // A write to a slot beats a simultaneous clear, so that slot stays valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_mem[i] <= '0;
            end
            slot_valid <= '0;
            key_err    <= 1'b0;
        end else begin
            key_err <= key_we && !wr_in_range;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (key_we && (key_idx == IDX_W'(i))) begin
                    key_mem[i]    <= key_data;
                    slot_valid[i] <= 1'b1;
                end else if (key_clear) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Indices beyond the last slot match nothing and read back as a miss.
    always_comb begin
        rd_key = '0;
        rd_hit = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_key = key_mem[i];
                rd_hit = slot_valid[i];
            end
        end
    end

endmodule

// File: rtl/add_round_key_stream.sv
// Streaming AddRoundKey: XORs each accepted state block with its tagged round
// key and presents the result through a one-deep back-pressurable register.
module add_round_key_stream
    import aes_pkg::*;
#(
    parameter int DATA_W     = AES_BLOCK_W,
    parameter int NUM_ROUNDS = AES128_NR,
    parameter int IDX_W      = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_we,
    input  logic [IDX_W-1:0]  key_idx,
    input  logic [DATA_W-1:0] key_data,
    input  logic              key_clear,
    output logic              key_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_round,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  block_cnt
);

    localparam int NUM_KEYS = NUM_ROUNDS + 1;

    logic [DATA_W-1:0] sel_key;
    logic              sel_hit;
    logic              accept;
    logic              ready_en;

    // The bank's read port sees pre-edge contents, so a same-cycle key write
    // only affects blocks accepted after it.
    round_key_bank #(
        .DATA_W   (DATA_W),
        .NUM_KEYS (NUM_KEYS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_we    (key_we),
        .key_idx   (key_idx),
        .key_data  (key_data),
        .key_clear (key_clear),
        .key_err   (key_err),
        .rd_idx    (in_round),
        .rd_key    (sel_key),
        .rd_hit    (sel_hit)
    );

    // ready_en keeps in_ready low through reset and until the first clock after it.
    assign in_ready = ready_en && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            block_cnt <= '0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= sel_hit ? (in_data ^ sel_key) : in_data;
                out_err   <= !sel_hit;
                block_cnt <= block_cnt + CNT_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
